// File: rtl/bmm_pkg.sv
// Shared definitions for the block-matrix datapath: tile geometry defaults
// and the output-register state encoding used by the packer and matrix_fill.
package bmm_pkg;

  localparam int BMM_ELEM_W = 4;
  localparam int BMM_ROWS   = 2;
  localparam int BMM_COLS   = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/matrix_row_packer.sv
// Packs a row-major element stream into one tile word (element 0 in the MSB slot),
// with a single-entry output register that hands tiles to matrix_fill.
//
// state | meaning
// EMPTY | no tile word waiting for downstream
// FULL  | out_data holds a complete tile; out_valid high
module matrix_row_packer
  import bmm_pkg::*;
#(
  parameter int ELEM_W = BMM_ELEM_W,
  parameter int ROWS   = BMM_ROWS,
  parameter int COLS   = BMM_COLS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [ELEM_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [ROWS*COLS*ELEM_W-1:0] out_data,
  input  logic                        out_ready,
  output logic [15:0]                 tile_count
);

  localparam int N      = ROWS * COLS;
  localparam int WORD_W = N * ELEM_W;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

  out_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] word_next;
  logic              completes;
  logic              stalled;
  logic              accept;
  logic              handoff;

  assign completes = (cnt == CNT_W'(N - 1)) || in_last;
  assign stalled   = out_valid && !out_ready;
  // Only a completing element needs the output register, so only it can stall.
  assign in_ready  = !(completes && stalled);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign out_valid = (state == FULL);

  // Unfilled slots are already zero in asm_q, so an early in_last needs no masking.
  always_comb begin
    word_next = asm_q;
    for (int k = 0; k < N; k++) begin
      if (cnt == CNT_W'(k)) begin
        word_next[WORD_W-1-k*ELEM_W -: ELEM_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      cnt        <= '0;
      asm_q      <= '0;
      out_data   <= '0;
      tile_count <= '0;
    end else begin
      if (handoff) begin
        tile_count <= tile_count + 16'd1;
      end

      if (accept) begin
        if (completes) begin
          out_data <= word_next;
          cnt      <= '0;
          asm_q    <= '0;
        end else begin
          asm_q <= word_next;
          cnt   <= cnt + 1'b1;
        end
      end

      if (accept && completes) begin
        state <= FULL;
      end else if (handoff) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_matrix_row_packer.sv
// Self-checking bench for matrix_row_packer: a queue-based tile model checked every
// cycle, directed scenarios with literal expectations, random traffic, and counter wrap.
module tb_matrix_row_packer;
  import bmm_pkg::*;

  localparam int ELEM_W = BMM_ELEM_W;
  localparam int N      = BMM_ROWS * BMM_COLS;
  localparam int WORD_W = N * ELEM_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [15:0]       tile_count;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_row_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .tile_count (tile_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: elements of the tile in progress, the pending output word,
  // and the handoff count. Updated at each falling edge for the coming rising edge.
  logic [ELEM_W-1:0] m_elems[$];
  bit                m_full = 0;
  logic [WORD_W-1:0] m_word = '0;
  logic [15:0]       m_count = '0;
  bit                m_live = 0;

  always @(negedge clk) begin
    bit comp, exp_ready, acc, hand;
    logic [WORD_W-1:0] w;
    if (m_live) begin
      chk("out_valid", 64'(out_valid), 64'(m_full));
      if (m_full) chk("out_data", 64'(out_data), 64'(m_word));
      chk("tile_count", 64'(tile_count), 64'(m_count));
    end
    if (rst) begin
      m_elems.delete();
      m_full  = 0;
      m_word  = '0;
      m_count = '0;
      m_live  = 1;
    end else if (m_live) begin
      comp      = (m_elems.size() == N - 1) || in_last;
      exp_ready = !(comp && m_full && !out_ready);
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      acc  = in_valid && exp_ready;
      hand = m_full && out_ready;
      if (hand) m_count = m_count + 16'd1;
      if (acc) begin
        m_elems.push_back(in_data);
        if (comp) begin
          w = '0;
          for (int i = 0; i < m_elems.size(); i++) w[WORD_W-1-i*ELEM_W -: ELEM_W] = m_elems[i];
          m_word = w;
          m_full = 1;
          m_elems.delete();
        end else if (hand) begin
          m_full = 0;
        end
      end else if (hand) begin
        m_full = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ELEM_W-1:0] d, input logic l);
    int  b;
    logic r;
    b = 0;
    r = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      r = in_ready;
      step();
      b++;
    end while (!r && b < 50);
    if (!r) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [ELEM_W-1:0] pat[8];
    int b;
    pat = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};

    repeat (2) step();
    rst = 1'b0;

    // Back-to-back full tile with downstream always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
    chk("t_full_valid", 64'(out_valid), 64'd1);
    chk("t_full_data", 64'(out_data), 64'h01011101);
    chk("t_full_model", 64'(m_word), 64'h01011101);
    step();
    chk("t_full_drained", 64'(out_valid), 64'd0);
    chk("t_full_count", 64'(tile_count), 64'd1);

    // Short tile closed by in_last, then a fresh tile must start at slot 0
    send(4'h3, 1'b0);
    send(4'h7, 1'b0);
    send(4'hF, 1'b1);
    chk("t_short_data", 64'(out_data), 64'h37F00000);
    for (int i = 1; i <= 8; i++) send(ELEM_W'(i), 1'b0);
    chk("t_after_short", 64'(out_data), 64'h12345678);
    chk("t_after_short_cnt", 64'(tile_count), 64'd2);
    step();

    // Backpressure: first word held, 16th element stalls until out_ready pulses
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(ELEM_W'(i), 1'b0);
    chk("t_bp_held", 64'(out_data), 64'h01234567);
    in_valid = 1'b1;
    in_data  = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("t_bp_stall", 64'(in_ready), 64'd0);
      chk("t_bp_hold", 64'(out_data), 64'h01234567);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t_bp_release", 64'(in_ready), 64'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t_bp_nobubble", 64'(out_valid), 64'd1);
    chk("t_bp_second", 64'(out_data), 64'h89ABCDEF);
    chk("t_bp_count", 64'(tile_count), 64'd4);

    // Reset with a partial tile and a pending FULL word
    for (int i = 0; i < 5; i++) send(4'h5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t_rst_valid", 64'(out_valid), 64'd0);
    chk("t_rst_count", 64'(tile_count), 64'd0);
    chk("t_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(ELEM_W'(15 - i), 1'b0);
    chk("t_rst_fresh", 64'(out_data), 64'hFEDCBA98);
    step();
    chk("t_rst_fresh_cnt", 64'(tile_count), 64'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = ELEM_W'($urandom);
      in_last   = ($urandom_range(0, 99) < 10);
      out_ready = ($urandom_range(0, 99) < 55);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // tile_count wrap: one-element tiles every cycle
    rst = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    b = 0;
    while (tile_count != 16'hFFFF && b < 70000) begin
      in_data = ELEM_W'($urandom);
      step();
      b++;
    end
    chk("t_wrap_reach", 64'(tile_count), 64'hFFFF);
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    chk("t_wrap_zero", 64'(tile_count), 64'h0000);
    chk("t_wrap_empty", 64'(out_valid), 64'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_row_packer.md
MATRIX_ROW_PACKER -- requirements
Module: matrix_row_packer

Interface
REQ-001 SHALL have parameter ELEM_W, default 4, bit width of one matrix element.
REQ-002 SHALL have parameter ROWS, default 2, matrix rows per tile.
REQ-003 SHALL have parameter COLS, default 4, matrix columns per tile.
REQ-004 SHALL have derived localparam N = ROWS*COLS (8) and WORD_W = N*ELEM_W (32).
REQ-005 SHALL use one clock and a synchronous active-high reset; clock and reset are the first ports.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  an element is offered on in_data.
REQ-009 in_data  input  ELEM_W  element value, row-major order.
REQ-010 in_last  input  1  offered element is the final element of a short tile.
REQ-011 in_ready  output  1  packer accepts the element this cycle.
REQ-012 out_valid  output  1  out_data holds a complete packed tile word.
REQ-013 out_data  output  WORD_W  packed tile word, the A_rows input of matrix_fill.
REQ-014 out_ready  input  1  downstream consumes out_data this cycle.
REQ-015 tile_count  output  16  number of tiles handed off since reset, wrapping modulo 2^16.

Function
REQ-016 SHALL accept an element when in_valid && in_ready are both high at a rising edge.
REQ-017 SHALL place accepted element k (k = 0..N-1, row r = k/COLS, column c = k%COLS) at out_data bits [WORD_W-1-k*ELEM_W -: ELEM_W], so element 0 occupies the MSB nibble.
REQ-018 SHALL keep an assembly register and an element counter cnt (0..N-1); each acceptance writes the element slot and increments cnt.
REQ-019 SHALL complete a tile when the accepted element has cnt == N-1 or has in_last high.
REQ-020 SHALL zero every unfilled slot of a tile completed early by in_last.
REQ-021 SHALL transfer a completed tile to the output register in the same edge as the acceptance, so out_valid is high in the following cycle (latency 1), and SHALL reset cnt and the assembly register to 0.
REQ-022 Output-register FSM: EMPTY -> FULL on tile completion; FULL -> EMPTY on out_valid && out_ready with no simultaneous completion; FULL -> FULL with new data when the handoff and a completion coincide.
REQ-023 SHALL drive out_valid high exactly in state FULL and SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-024 SHALL drive in_ready low only when the offered element would complete a tile (cnt == N-1 or in_last) while out_valid is high and out_ready is low; otherwise in_ready is high.
REQ-025 SHALL compute in_ready combinationally from cnt, in_last, out_valid and out_ready, with no dependency on in_valid.
REQ-026 SHALL increment tile_count on each out_valid && out_ready handoff, wrapping 0xFFFF -> 0x0000.
REQ-027 SHALL treat in_last together with cnt == N-1 as a single normal completion.

Reset
REQ-028 On rst high at a clock edge, SHALL clear cnt, the assembly register, out_data, out_valid and tile_count to 0, and SHALL enter state EMPTY.
REQ-029 Reset asserted mid-tile SHALL discard the partial tile; a pending FULL word SHALL be dropped without a handoff.
REQ-030 in_ready SHALL be high in the first cycle after reset release.

Structure
REQ-031 SHALL place ELEM_W, ROWS, COLS defaults and the FSM state encoding (EMPTY, FULL) in shared package bmm_pkg, which matrix_fill also uses.
REQ-032 SHALL be a single module with no sub-modules; the output stage is inline, not a separate FIFO.

Verification
REQ-033 Feed elements 0,1,0,1,1,1,0,1 back-to-back with out_ready=1 -> out_data 32'h01011101, out_valid high for one cycle after the 8th acceptance, tile_count=1.
REQ-034 Feed 3,7,F with in_last on F -> out_data 32'h37F00000, and the next tile starts at slot 0.
REQ-035 Hold out_ready=0 and stream 16 elements -> first word held stable; in_ready low on the 16th element until out_ready pulses; the second word appears the cycle after.
REQ-036 Assert out_ready in the same cycle the next tile's 8th element is accepted -> old word handed off, new word valid next cycle with no bubble, tile_count advances by 1.
REQ-037 Assert rst after 5 elements and with a FULL word pending -> out_valid=0, tile_count=0; the next 8 elements form a clean fresh word.
REQ-038 Force tile_count to 0xFFFF, then complete one handoff -> tile_count=0x0000.
